// File: rtl/mem_port_arbiter_if.sv
// Bundle of the icache, dcache and memory-port signals seen by mem_port_arbiter.
// The arbiter uses modport slave; the caches plus memory side use modport master.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Handshakes: icache_read / dcache_rw_flag are level requests held until their done pulse
  // (icache_valid, dcache_read_valid, dcache_write_valid: one cycle each); mem_req is held with
  // stable mem_we/addr/wdata/mask until a one-cycle mem_ack, which qualifies mem_rdata.
  logic                  icache_read;
  logic [ADDR_WIDTH-1:0] icache_addr;
  logic                  icache_valid;
  logic [DATA_WIDTH-1:0] icache_inst;

  logic [1:0]            dcache_rw_flag;
  logic [ADDR_WIDTH-1:0] dcache_addr;
  logic [DATA_WIDTH-1:0] dcache_write_data;
  logic [3:0]            dcache_write_mask;
  logic                  dcache_read_valid;
  logic [DATA_WIDTH-1:0] dcache_read_data;
  logic                  dcache_write_valid;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_mask;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  icache_read, icache_addr,
    input  dcache_rw_flag, dcache_addr, dcache_write_data, dcache_write_mask,
    input  mem_ack, mem_rdata,
    output icache_valid, icache_inst,
    output dcache_read_valid, dcache_read_data, dcache_write_valid,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_mask
  );

  modport master (
    output icache_read, icache_addr,
    output dcache_rw_flag, dcache_addr, dcache_write_data, dcache_write_mask,
    output mem_ack, mem_rdata,
    input  icache_valid, icache_inst,
    input  dcache_read_valid, dcache_read_data, dcache_write_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache (read-only) and dcache (read/write).
// Optional MEM_ARB_RR_EN: round-robin ties instead of dcache priority with a starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          state_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         starve_q, starve_d;
  logic                  last_d_q, last_d_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            mask_q, mask_d;
  logic                  ivalid_q, ivalid_d;
  logic                  rvalid_q, rvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic i_req, d_rd, d_wr, d_req, grant_i, grant_d;

  // Reserved flag 2'b11 decodes as neither read nor write, i.e. no request.
  always_comb begin
    i_req = bus.icache_read;
    d_rd  = (bus.dcache_rw_flag == 2'b01);
    d_wr  = (bus.dcache_rw_flag == 2'b10);
    d_req = d_rd | d_wr;
`ifdef MEM_ARB_RR_EN
    grant_i = i_req && (!d_req || last_d_q);
`else
    grant_i = i_req && (!d_req || (starve_q == LIMIT));
`endif
    grant_d = d_req && !grant_i;
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    last_d_d = last_d_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    ivalid_d = 1'b0;
    rvalid_d = 1'b0;
    wvalid_d = 1'b0;
    inst_d   = inst_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d  = BUSY_I;
          we_d     = 1'b0;
          addr_d   = bus.icache_addr;
          wdata_d  = '0;
          mask_d   = 4'b0000;
          last_d_d = 1'b0;
        end else if (grant_d) begin
          state_d  = BUSY_D;
          we_d     = d_wr;
          addr_d   = bus.dcache_addr;
          wdata_d  = d_wr ? bus.dcache_write_data : '0;
          mask_d   = d_wr ? bus.dcache_write_mask : 4'b0000;
          last_d_d = 1'b1;
        end
`ifndef MEM_ARB_RR_EN
        // Counts dcache wins that left a waiting icache behind; saturates at the limit.
        if (!i_req || grant_i) begin
          starve_d = '0;
        end else if (grant_d && (starve_q != LIMIT)) begin
          starve_d = starve_q + CW'(1);
        end
`endif
      end
      BUSY_I: begin
        if (bus.mem_ack) begin
          state_d  = RELEASE;
          ivalid_d = 1'b1;
          inst_d   = bus.mem_rdata;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack) begin
          state_d = RELEASE;
          if (we_q) begin
            wvalid_d = 1'b1;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = bus.mem_rdata;
          end
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      last_d_q <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= 4'b0000;
      ivalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      inst_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      last_d_q <= last_d_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      ivalid_q <= ivalid_d;
      rvalid_q <= rvalid_d;
      wvalid_q <= wvalid_d;
      inst_q   <= inst_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.mem_req            = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign bus.mem_we             = we_q;
  assign bus.mem_addr           = addr_q;
  assign bus.mem_wdata          = wdata_q;
  assign bus.mem_mask           = mask_q;
  assign bus.icache_valid       = ivalid_q;
  assign bus.icache_inst        = inst_q;
  assign bus.dcache_read_valid  = rvalid_q;
  assign bus.dcache_read_data   = rdata_q;
  assign bus.dcache_write_valid = wvalid_q;
  assign state_o                = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
  localparam int FW    = 1 + AW + DW + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state_dbg;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  // reference model state
  bit             i_on, d_on, d_wr;
  int             cnt_m;
  bit             last_d_m;
  int             owner;        // 0 none, 1 icache, 2 dcache
  logic [FW-1:0]  cur_exp;
  int             ack_wait, ack_delay;
  bit             use_fixed;
  logic [DW-1:0]  fixed_rdata;
  logic [DW+1:0]  exp_q[$];     // {kind, data}: 1 icache, 2 dcache read, 3 dcache write
  bit             grant_log[$]; // 1 = icache grant
  int             grant_count = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] fields();
    return {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_mask};
  endfunction

  function automatic logic [2:0] pulses();
    return {bus.icache_valid, bus.dcache_read_valid, bus.dcache_write_valid};
  endfunction

  task automatic do_reset();
    rst                   = 1'b0;
    bus.icache_read       = 1'b0;
    bus.icache_addr       = '0;
    bus.dcache_rw_flag    = 2'b00;
    bus.dcache_addr       = '0;
    bus.dcache_write_data = '0;
    bus.dcache_write_mask = 4'b0000;
    bus.mem_ack           = 1'b0;
    bus.mem_rdata         = '0;
    i_on = 1'b0; d_on = 1'b0; d_wr = 1'b0;
    cnt_m = 0; last_d_m = 1'b1; owner = 0; ack_wait = 0;
    exp_q.delete();
    grant_log.delete();
    repeat (2) @(negedge clk);
    check("reset_ctrl", {pulses(), bus.mem_req, bus.mem_we, bus.mem_mask}, '0);
    check("reset_data", {bus.icache_inst, bus.dcache_read_data}, '0);
    check("reset_bus", {bus.mem_addr, bus.mem_wdata}, '0);
    check("reset_state_known", $isunknown(state_dbg), 1'b0);
    rst = 1'b1;
  endtask

  // One cycle at the negedge: check outputs, update the model, then drive new inputs.
  // mode 0 random traffic, 1 both requesters always pending, 2 directed (no new requests).
  task automatic step(input int mode);
    logic [DW+1:0] e;
    logic [2:0]    exp_p;
    logic [DW-1:0] rd;
    bit            win_i, i_done, d_done, do_ack;
    exp_p  = 3'b000;
    i_done = 1'b0;
    d_done = 1'b0;
    win_i  = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e[DW+1:DW])
        2'd1:    begin exp_p = 3'b100; i_done = 1'b1; end
        2'd2:    begin exp_p = 3'b010; d_done = 1'b1; end
        default: begin exp_p = 3'b001; d_done = 1'b1; end
      endcase
      check("req_drop", bus.mem_req, 1'b0);
      if (e[DW+1:DW] == 2'd1) check("icache_inst", bus.icache_inst, e[DW-1:0]);
      if (e[DW+1:DW] == 2'd2) check("dcache_read_data", bus.dcache_read_data, e[DW-1:0]);
    end
    check("done_pulses", pulses(), exp_p);

    if (bus.mem_req && owner == 0) begin
      if (!i_on && !d_on) begin
        check("spurious_grant", bus.mem_req, 1'b0);
      end else if (i_on && d_on) begin
`ifdef MEM_ARB_RR_EN
        win_i = last_d_m;
`else
        win_i = (cnt_m >= LIMIT);
`endif
      end else begin
        win_i = i_on;
      end
      if (win_i)     cnt_m = 0;
      else if (i_on) cnt_m = (cnt_m < LIMIT) ? cnt_m + 1 : LIMIT;
      else           cnt_m = 0;
      last_d_m = !win_i;
      grant_log.push_back(win_i);
      grant_count++;
      owner = win_i ? 1 : 2;
      if (win_i)
        cur_exp = {1'b0, bus.icache_addr, {DW{1'b0}}, 4'b0000};
      else
        cur_exp = {d_wr, bus.dcache_addr, d_wr ? bus.dcache_write_data : {DW{1'b0}},
                   d_wr ? bus.dcache_write_mask : 4'b0000};
      check("grant_fields", fields(), cur_exp);
      ack_wait = 0;
    end else if (owner != 0) begin
      if (bus.mem_req) check("hold_fields", fields(), cur_exp);
      else             check("req_lost", bus.mem_req, 1'b1);
    end

    if (i_done) begin i_on = 1'b0; bus.icache_read = 1'b0; end
    if (d_done) begin d_on = 1'b0; bus.dcache_rw_flag = 2'b00; end

    // memory responder
    bus.mem_ack = 1'b0;
    if (owner != 0) begin
      ack_wait++;
      do_ack = (mode == 0) ? ($urandom_range(0, 2) == 0 || ack_wait >= 4) : (ack_wait >= ack_delay);
      if (do_ack) begin
        rd = use_fixed ? fixed_rdata : DW'($urandom);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        exp_q.push_back({(owner == 1) ? 2'd1 : (cur_exp[FW-1] ? 2'd3 : 2'd2), rd});
        owner = 0;
      end else if (mode == 2 || (mode == 0 && $urandom_range(0, 1) == 0)) begin
        if (owner == 1) begin
          bus.icache_addr = AW'($urandom);
        end else begin
          bus.dcache_addr       = AW'($urandom);
          bus.dcache_write_data = DW'($urandom);
          bus.dcache_write_mask = 4'($urandom_range(0, 15));
        end
      end
    end else if (!bus.mem_req && mode == 0 && $urandom_range(0, 4) == 0) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = DW'($urandom);
    end

    // requesters
    if (!i_on && (mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0))) begin
      i_on            = 1'b1;
      bus.icache_read = 1'b1;
      bus.icache_addr = AW'($urandom);
    end
    if (!d_on) begin
      if (mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0)) begin
        d_on  = 1'b1;
        d_wr  = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.dcache_rw_flag    = d_wr ? 2'b10 : 2'b01;
        bus.dcache_addr       = AW'($urandom);
        bus.dcache_write_data = DW'($urandom);
        bus.dcache_write_mask = 4'($urandom_range(0, 15));
      end else if (mode == 0) begin
        bus.dcache_rw_flag = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      end
    end
  endtask

  initial begin
    int g0;
    logic [9:0] exp_order;
    use_fixed = 1'b0;
    ack_delay = 1;
    do_reset();

    // reset while BUSY_D abandons the transfer; a late ack is ignored
    d_on = 1'b1; d_wr = 1'b0;
    bus.dcache_rw_flag = 2'b01;
    bus.dcache_addr    = 32'h80;
    for (int i = 0; i < 5 && !bus.mem_req; i++) @(negedge clk);
    check("t1_req_up", bus.mem_req, 1'b1);
    rst = 1'b0;
    bus.dcache_rw_flag = 2'b00;
    d_on = 1'b0;
    @(negedge clk);
    check("t1_req_after_rst", bus.mem_req, 1'b0);
    check("t1_pulses_after_rst", pulses(), 3'b000);
    rst = 1'b1;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("t1_late_ack_pulses", pulses(), 3'b000);
    check("t1_late_ack_req", bus.mem_req, 1'b0);
    @(negedge clk);
    check("t1_late_ack_pulses2", pulses(), 3'b000);

    // icache fetch at 0x100
    do_reset();
    g0 = grant_count;
    i_on = 1'b1;
    bus.icache_read = 1'b1;
    bus.icache_addr = 32'h100;
    use_fixed   = 1'b1;
    fixed_rdata = 32'hDEADBEEF;
    ack_delay   = 3;
    repeat (10) begin @(negedge clk); step(2); end
    check("t2_grants", grant_count - g0, 1);
    check("t2_inst", bus.icache_inst, 32'hDEADBEEF);
    check("t2_addr", bus.mem_addr, 32'h100);

    // dcache write at 0x20
    g0 = grant_count;
    d_on = 1'b1; d_wr = 1'b1;
    bus.dcache_rw_flag    = 2'b10;
    bus.dcache_addr       = 32'h20;
    bus.dcache_write_data = 32'h12345678;
    bus.dcache_write_mask = 4'b0011;
    fixed_rdata = 32'hA5A5A5A5;
    ack_delay   = 1;
    repeat (8) begin @(negedge clk); step(2); end
    check("t3_grants", grant_count - g0, 1);
    check("t3_we_mask", {bus.mem_we, bus.mem_mask}, 5'b10011);
    check("t3_wdata", bus.mem_wdata, 32'h12345678);

    // stray ack in IDLE, then a dcache read whose address is changed while busy
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("t6_idle_ack_pulses", pulses(), 3'b000);
    check("t6_idle_ack_req", bus.mem_req, 1'b0);
    d_on = 1'b1; d_wr = 1'b0;
    bus.dcache_rw_flag = 2'b01;
    bus.dcache_addr    = 32'h40;
    fixed_rdata = 32'hCAFEF00D;
    ack_delay   = 3;
    repeat (10) begin @(negedge clk); step(2); end
    check("t6_addr", bus.mem_addr, 32'h40);
    check("t6_rdata", bus.dcache_read_data, 32'hCAFEF00D);

    // both requesters always pending: fixed grant order
    do_reset();
    use_fixed = 1'b0;
    ack_delay = 1;
    repeat (40) begin @(negedge clk); step(1); end
`ifdef MEM_ARB_RR_EN
    exp_order = 10'b1010101010;
`else
    exp_order = 10'b0000100001;
`endif
    check("order_count", grant_log.size() >= 10, 1'b1);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      check($sformatf("grant_order[%0d]", i), grant_log[i], exp_order[9-i]);

    // randomized traffic
    do_reset();
    g0 = grant_count;
    repeat (3000) begin @(negedge clk); step(0); end
    check("random_grants_seen", (grant_count - g0) > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
